fpu_fmac_sched: RTL and testbench

FPU_FMAC_SCHED -- requirements
Module: fpu_fmac_sched

---
 rtl/fpu_fmac_sched.sv | 266 ++++++++++++++++++++++++++
 tb/tb_fpu_fmac_sched.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_fmac_sched.sv
// fpu_fmac_sched: two-requester front end for a fixed-latency FMAC datapath.
// Round-robin arbitration, one-cycle issue register, {valid,id} tag pipeline
// that tracks ops through the datapath, per-requester result registers,
// outstanding-op limits and an IDLE/RUN/DRAIN flush FSM.
// Optional feature: define FPU_FMAC_SCHED_STALL_CNT_EN to add the saturating
// 16-bit Stall_Cnt_DO output (cycles with a pending request and no accept).
module fpu_fmac_sched #(
    parameter int C_LATENCY   = 3,
    parameter int C_MAX_OUTST = 4,
    parameter int C_FMAC_RM   = 3
) (
    input  logic                 Clk_CI,
    input  logic                 Rst_RI,
    input  logic                 Req0_Valid_SI,
    output logic                 Req0_Ready_SO,
    input  logic [31:0]          Req0_OpA_DI,
    input  logic [31:0]          Req0_OpB_DI,
    input  logic [31:0]          Req0_OpC_DI,
    input  logic [C_FMAC_RM-1:0] Req0_RM_DI,
    input  logic                 Req1_Valid_SI,
    output logic                 Req1_Ready_SO,
    input  logic [31:0]          Req1_OpA_DI,
    input  logic [31:0]          Req1_OpB_DI,
    input  logic [31:0]          Req1_OpC_DI,
    input  logic [C_FMAC_RM-1:0] Req1_RM_DI,
    output logic                 Res0_Valid_SO,
    output logic [31:0]          Res0_Result_DO,
    output logic [2:0]           Res0_Flags_DO,
    output logic                 Res1_Valid_SO,
    output logic [31:0]          Res1_Result_DO,
    output logic [2:0]           Res1_Flags_DO,
    output logic                 Fmac_Valid_SO,
    output logic [31:0]          Fmac_OpA_DO,
    output logic [31:0]          Fmac_OpB_DO,
    output logic [31:0]          Fmac_OpC_DO,
    output logic [C_FMAC_RM-1:0] Fmac_RM_DO,
    input  logic                 Fmac_Valid_SI,
    input  logic [31:0]          Fmac_Result_DI,
    input  logic [2:0]           Fmac_Flags_DI,
    input  logic                 Flush_SI,
    output logic                 Busy_SO,
    output logic                 Err_SO
`ifdef FPU_FMAC_SCHED_STALL_CNT_EN
    ,
    output logic [15:0]          Stall_Cnt_DO
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [3:0] MAX_OUTST = 4'(C_MAX_OUTST);

    state_t               state_q, state_d;
    logic                 ptr_q, ptr_d;
    logic [3:0]           outst0_q, outst0_d;
    logic [3:0]           outst1_q, outst1_d;
    logic                 err_q, err_d;

    logic                 fmac_valid_q, fmac_valid_d;
    logic                 fmac_id_q, fmac_id_d;
    logic [31:0]          fmac_opa_q, fmac_opa_d;
    logic [31:0]          fmac_opb_q, fmac_opb_d;
    logic [31:0]          fmac_opc_q, fmac_opc_d;
    logic [C_FMAC_RM-1:0] fmac_rm_q, fmac_rm_d;

    logic [C_LATENCY-1:0] tag_vld_q, tag_vld_d;
    logic [C_LATENCY-1:0] tag_id_q, tag_id_d;

    logic                 res0_valid_q, res0_valid_d;
    logic [31:0]          res0_result_q, res0_result_d;
    logic [2:0]           res0_flags_q, res0_flags_d;
    logic                 res1_valid_q, res1_valid_d;
    logic [31:0]          res1_result_q, res1_result_d;
    logic [2:0]           res1_flags_q, res1_flags_d;

    logic elig0, elig1, gnt0, gnt1, accept;
    logic tail_vld, tail_id, deliver, pipe_empty;

    // Arbitration: a result leaving this cycle frees a slot immediately, so a
    // full requester may re-issue in the same cycle its result pulses.
    always_comb begin
        elig0 = Req0_Valid_SI && ((outst0_q < MAX_OUTST) || res0_valid_q) &&
                (state_q != DRAIN) && !Flush_SI && !Rst_RI;
        elig1 = Req1_Valid_SI && ((outst1_q < MAX_OUTST) || res1_valid_q) &&
                (state_q != DRAIN) && !Flush_SI && !Rst_RI;
        gnt0   = elig0 && (!elig1 || !ptr_q);
        gnt1   = elig1 && (!elig0 || ptr_q);
        accept = gnt0 || gnt1;
        ptr_d  = accept ? gnt0 : ptr_q;
    end

    // Issue register: capture the granted operands, hold them otherwise.
    always_comb begin
        fmac_valid_d = accept;
        fmac_id_d    = gnt1;
        fmac_opa_d   = fmac_opa_q;
        fmac_opb_d   = fmac_opb_q;
        fmac_opc_d   = fmac_opc_q;
        fmac_rm_d    = fmac_rm_q;
        if (gnt0) begin
            fmac_opa_d = Req0_OpA_DI;
            fmac_opb_d = Req0_OpB_DI;
            fmac_opc_d = Req0_OpC_DI;
            fmac_rm_d  = Req0_RM_DI;
        end else if (gnt1) begin
            fmac_opa_d = Req1_OpA_DI;
            fmac_opb_d = Req1_OpB_DI;
            fmac_opc_d = Req1_OpC_DI;
            fmac_rm_d  = Req1_RM_DI;
        end
    end

    // Tag pipeline follows the issued op; its tail lines up with Fmac_Valid_SI.
    always_comb begin
        tag_vld_d    = '0;
        tag_id_d     = '0;
        tag_vld_d[0] = fmac_valid_q;
        tag_id_d[0]  = fmac_id_q;
        for (int i = 1; i < C_LATENCY; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_id_d[i]  = tag_id_q[i-1];
        end
    end

    // Result routing by tail tag; any valid/tag disagreement is a sticky error.
    always_comb begin
        tail_vld      = tag_vld_q[C_LATENCY-1];
        tail_id       = tag_id_q[C_LATENCY-1];
        deliver       = Fmac_Valid_SI && tail_vld;
        err_d         = err_q || (Fmac_Valid_SI != tail_vld);
        res0_valid_d  = deliver && !tail_id;
        res1_valid_d  = deliver && tail_id;
        res0_result_d = res0_valid_d ? Fmac_Result_DI : res0_result_q;
        res0_flags_d  = res0_valid_d ? Fmac_Flags_DI  : res0_flags_q;
        res1_result_d = res1_valid_d ? Fmac_Result_DI : res1_result_q;
        res1_flags_d  = res1_valid_d ? Fmac_Flags_DI  : res1_flags_q;
    end

    // Outstanding counters: accept and result in the same cycle cancel out.
    always_comb begin
        outst0_d = outst0_q;
        outst1_d = outst1_q;
        if (gnt0 && !res0_valid_q && (outst0_q != 4'hF))
            outst0_d = outst0_q + 4'd1;
        else if (!gnt0 && res0_valid_q && (outst0_q != 4'h0))
            outst0_d = outst0_q - 4'd1;
        if (gnt1 && !res1_valid_q && (outst1_q != 4'hF))
            outst1_d = outst1_q + 4'd1;
        else if (!gnt1 && res1_valid_q && (outst1_q != 4'h0))
            outst1_d = outst1_q - 4'd1;
    end

    // Next-state logic; "empty" uses post-update counters so the FSM can go
    // idle in the cycle right after the last result pulse.
    always_comb begin
        pipe_empty = (outst0_d == 4'd0) && (outst1_d == 4'd0) &&
                     !fmac_valid_q && (tag_vld_q == '0);
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (Flush_SI)    state_d = DRAIN;
                else if (accept) state_d = RUN;
            end
            RUN: begin
                if (Flush_SI)                    state_d = DRAIN;
                else if (!accept && pipe_empty)  state_d = IDLE;
            end
            DRAIN: begin
                if (!Flush_SI && pipe_empty) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state registers.
    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            state_q  <= IDLE;
            ptr_q    <= 1'b0;
            outst0_q <= '0;
            outst1_q <= '0;
            err_q    <= 1'b0;
            tag_vld_q <= '0;
            tag_id_q  <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            outst0_q <= outst0_d;
            outst1_q <= outst1_d;
            err_q    <= err_d;
            tag_vld_q <= tag_vld_d;
            tag_id_q  <= tag_id_d;
        end
    end

    // Datapath-facing and requester-facing registers.
    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            fmac_valid_q  <= 1'b0;
            fmac_id_q     <= 1'b0;
            fmac_opa_q    <= '0;
            fmac_opb_q    <= '0;
            fmac_opc_q    <= '0;
            fmac_rm_q     <= '0;
            res0_valid_q  <= 1'b0;
            res0_result_q <= '0;
            res0_flags_q  <= '0;
            res1_valid_q  <= 1'b0;
            res1_result_q <= '0;
            res1_flags_q  <= '0;
        end else begin
            fmac_valid_q  <= fmac_valid_d;
            fmac_id_q     <= fmac_id_d;
            fmac_opa_q    <= fmac_opa_d;
            fmac_opb_q    <= fmac_opb_d;
            fmac_opc_q    <= fmac_opc_d;
            fmac_rm_q     <= fmac_rm_d;
            res0_valid_q  <= res0_valid_d;
            res0_result_q <= res0_result_d;
            res0_flags_q  <= res0_flags_d;
            res1_valid_q  <= res1_valid_d;
            res1_result_q <= res1_result_d;
            res1_flags_q  <= res1_flags_d;
        end
    end

`ifdef FPU_FMAC_SCHED_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Count cycles where someone wants to issue but nothing is accepted.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((Req0_Valid_SI || Req1_Valid_SI) && !accept && (stall_cnt_q != 16'hFFFF))
            stall_cnt_d = stall_cnt_q + 16'd1;
    end

    // Stall counter register.
    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) stall_cnt_q <= '0;
        else        stall_cnt_q <= stall_cnt_d;
    end

    assign Stall_Cnt_DO = stall_cnt_q;
`endif

    assign Req0_Ready_SO  = gnt0;
    assign Req1_Ready_SO  = gnt1;
    assign Fmac_Valid_SO  = fmac_valid_q;
    assign Fmac_OpA_DO    = fmac_opa_q;
    assign Fmac_OpB_DO    = fmac_opb_q;
    assign Fmac_OpC_DO    = fmac_opc_q;
    assign Fmac_RM_DO     = fmac_rm_q;
    assign Res0_Valid_SO  = res0_valid_q;
    assign Res0_Result_DO = res0_result_q;
    assign Res0_Flags_DO  = res0_flags_q;
    assign Res1_Valid_SO  = res1_valid_q;
    assign Res1_Result_DO = res1_result_q;
    assign Res1_Flags_DO  = res1_flags_q;
    assign Busy_SO        = (state_q != IDLE);
    assign Err_SO         = err_q;

endmodule

// File: tb/tb_fpu_fmac_sched.sv
// Directed bench for fpu_fmac_sched with a fixed-latency FMAC stub.
module tb_fpu_fmac_sched;
    localparam int LAT = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        r0_v, r0_rdy, r1_v, r1_rdy;
    logic [31:0] r0_a, r0_b, r0_c, r1_a, r1_b, r1_c;
    logic [2:0]  r0_rm, r1_rm;
    logic        s0_v, s1_v;
    logic [31:0] s0_r, s1_r;
    logic [2:0]  s0_f, s1_f;
    logic        f_vo, f_vi;
    logic [31:0] f_a, f_b, f_c, f_res;
    logic [2:0]  f_rm, f_flg;
    logic        flush, busy, err;
`ifdef FPU_FMAC_SCHED_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    fpu_fmac_sched dut (
        .Clk_CI(clk), .Rst_RI(rst),
        .Req0_Valid_SI(r0_v), .Req0_Ready_SO(r0_rdy),
        .Req0_OpA_DI(r0_a), .Req0_OpB_DI(r0_b), .Req0_OpC_DI(r0_c), .Req0_RM_DI(r0_rm),
        .Req1_Valid_SI(r1_v), .Req1_Ready_SO(r1_rdy),
        .Req1_OpA_DI(r1_a), .Req1_OpB_DI(r1_b), .Req1_OpC_DI(r1_c), .Req1_RM_DI(r1_rm),
        .Res0_Valid_SO(s0_v), .Res0_Result_DO(s0_r), .Res0_Flags_DO(s0_f),
        .Res1_Valid_SO(s1_v), .Res1_Result_DO(s1_r), .Res1_Flags_DO(s1_f),
        .Fmac_Valid_SO(f_vo), .Fmac_OpA_DO(f_a), .Fmac_OpB_DO(f_b), .Fmac_OpC_DO(f_c),
        .Fmac_RM_DO(f_rm),
        .Fmac_Valid_SI(f_vi), .Fmac_Result_DI(f_res), .Fmac_Flags_DI(f_flg),
        .Flush_SI(flush), .Busy_SO(busy), .Err_SO(err)
`ifdef FPU_FMAC_SCHED_STALL_CNT_EN
        , .Stall_Cnt_DO(stall_cnt)
`endif
    );

    // Arbitrary but deterministic datapath function of the issued operands.
    function automatic logic [31:0] fres(input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] c, input logic [2:0] rm);
        return a ^ {b[15:0], b[31:16]} ^ (c + 32'h1234_5678) ^ {29'd0, rm};
    endfunction

    function automatic logic [2:0] fflg(input logic [31:0] a, input logic [31:0] c);
        return a[2:0] ^ c[4:2];
    endfunction

    // Stimulus operand generators for the multi-op tests.
    function automatic logic [31:0] opa(input int r, input int t);
        return {(r != 0) ? 8'h20 : 8'h10, 24'(t)};
    endfunction
    function automatic logic [31:0] opb(input int r, input int t);
        return 32'h4000_0000 + 32'(t * 3 + r);
    endfunction
    function automatic logic [31:0] opc(input int r, input int t);
        return 32'h3F80_0000 ^ 32'(t << 4) ^ 32'(r);
    endfunction
    function automatic logic [2:0] oprm(input int r, input int t);
        return 3'(t + r);
    endfunction

    // FMAC stub: fixed LAT-cycle pipeline, plus a forced-valid injection.
    logic [LAT-1:0] st_v = '0;
    logic [31:0]    st_r [LAT];
    logic [2:0]     st_f [LAT];
    logic           force_v;
    always @(posedge clk) begin
        st_v    <= {st_v[LAT-2:0], f_vo};
        st_r[0] <= fres(f_a, f_b, f_c, f_rm);
        st_f[0] <= fflg(f_a, f_c);
        for (int i = 1; i < LAT; i++) begin
            st_r[i] <= st_r[i-1];
            st_f[i] <= st_f[i-1];
        end
    end
    assign f_vi  = st_v[LAT-1] | force_v;
    assign f_res = st_r[LAT-1];
    assign f_flg = st_f[LAT-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        r0_v = 0; r1_v = 0; flush = 0; force_v = 0;
        r0_a = 0; r0_b = 0; r0_c = 0; r0_rm = 0;
        r1_a = 0; r1_b = 0; r1_c = 0; r1_rm = 0;

        // Reset: ready held low even with a valid request.
        rst = 1'b1;
        r0_v = 1'b1;
        tick();
        settle();
        chk("rst_ready0", 32'(r0_rdy), 32'd0);
        tick();
        r0_v = 1'b0;
        rst  = 1'b0;
        settle();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_fvalid", 32'(f_vo), 32'd0);
        chk("rst_fopa", f_a, 32'd0);
        chk("rst_res0", s0_r, 32'd0);
        chk("rst_res0v", 32'(s0_v), 32'd0);
`ifdef FPU_FMAC_SCHED_STALL_CNT_EN
        chk("rst_stall", 32'(stall_cnt), 32'd0);
`endif

        // Single op on requester 0: issue at cycle 1, result at cycle 5.
        tick();
        r0_v = 1; r0_a = 32'h3F80_0000; r0_b = 32'h4000_0000; r0_c = 32'h4040_0000; r0_rm = 3'd0;
        settle();
        chk("t1_ready0", 32'(r0_rdy), 32'd1);
        chk("t1_ready1", 32'(r1_rdy), 32'd0);
        tick();
        r0_v = 0;
        settle();
        chk("t1_fvalid", 32'(f_vo), 32'd1);
        chk("t1_fopa", f_a, 32'h3F80_0000);
        chk("t1_fopb", f_b, 32'h4000_0000);
        chk("t1_fopc", f_c, 32'h4040_0000);
        tick();
        for (int t = 2; t <= 7; t++) begin
            settle();
            if (t == 2) begin
                chk("t1_fvalid_pulse", 32'(f_vo), 32'd0);
                chk("t1_fopa_hold", f_a, 32'h3F80_0000);
                chk("t1_busy", 32'(busy), 32'd1);
            end
            chk("t1_res0v", 32'(s0_v), 32'(t == 5));
            chk("t1_res1v", 32'(s1_v), 32'd0);
            if (t == 5) begin
                chk("t1_res0", s0_r, fres(32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 3'd0));
                chk("t1_flg0", 32'(s0_f), 32'(fflg(32'h3F80_0000, 32'h4040_0000)));
            end
            if (t == 7) chk("t1_idle", 32'(busy), 32'd0);
            tick();
        end

        // Both requesters valid for 6 cycles after reset: alternate grants.
        do_reset();
        for (int t = 0; t < 12; t++) begin
            if (t < 6) begin
                r0_v = 1; r0_a = opa(0, t); r0_b = opb(0, t); r0_c = opc(0, t); r0_rm = oprm(0, t);
                r1_v = 1; r1_a = opa(1, t); r1_b = opb(1, t); r1_c = opc(1, t); r1_rm = oprm(1, t);
            end else begin
                r0_v = 0; r1_v = 0;
            end
            settle();
            if (t < 6) begin
                chk("t2_ready0", 32'(r0_rdy), 32'(t % 2 == 0));
                chk("t2_ready1", 32'(r1_rdy), 32'(t % 2 == 1));
            end
            if (t >= 5 && t <= 10) begin
                int u, r;
                u = t - 5;
                r = u % 2;
                chk("t2_res0v", 32'(s0_v), 32'(r == 0));
                chk("t2_res1v", 32'(s1_v), 32'(r == 1));
                if (r == 0) chk("t2_res0", s0_r, fres(opa(0, u), opb(0, u), opc(0, u), oprm(0, u)));
                else        chk("t2_res1", s1_r, fres(opa(1, u), opb(1, u), opc(1, u), oprm(1, u)));
            end else begin
                chk("t2_res0v_idle", 32'(s0_v), 32'd0);
                chk("t2_res1v_idle", 32'(s1_v), 32'd0);
            end
            tick();
        end

        // Outstanding limit: 4 accepts, stall until the first result frees a slot.
        for (int t = 0; t < 10; t++) begin
            r0_v = 1; r0_a = opa(0, t + 20); r0_b = opb(0, t); r0_c = opc(0, t); r0_rm = 3'd1;
            settle();
            chk("t3_ready0", 32'(r0_rdy), 32'(!(t == 4 || t == 9)));
            tick();
        end
        r0_v = 0;
        for (int t = 0; t < 8; t++) tick();
        settle();
        chk("t3_idle", 32'(busy), 32'd0);
        tick();

        // Flush with 3 ops in flight: no accepts, results still delivered.
        for (int t = 0; t < 9; t++) begin
            flush = (t >= 3 && t <= 6);
            r0_v = (t <= 6);
            r1_v = (t >= 3 && t <= 6);
            r0_a = opa(0, t + 40); r0_b = opb(0, t); r0_c = opc(0, t); r0_rm = 3'd2;
            settle();
            if (t < 3) chk("t4_ready0", 32'(r0_rdy), 32'd1);
            if (t >= 3 && t <= 6) begin
                chk("t4_flush_rdy0", 32'(r0_rdy), 32'd0);
                chk("t4_flush_rdy1", 32'(r1_rdy), 32'd0);
                chk("t4_flush_busy", 32'(busy), 32'd1);
            end
            chk("t4_res0v", 32'(s0_v), 32'(t >= 5 && t <= 7));
            chk("t4_res1v", 32'(s1_v), 32'd0);
            if (t == 7) chk("t4_busy_last", 32'(busy), 32'd1);
            if (t == 8) chk("t4_idle", 32'(busy), 32'd0);
            tick();
        end
        r0_v = 0; r1_v = 0; flush = 0;

        // Forced datapath valid with no tag: sticky error, no result pulse.
        settle();
        chk("t5_err_before", 32'(err), 32'd0);
        force_v = 1;
        tick();
        force_v = 0;
        for (int t = 1; t <= 3; t++) begin
            settle();
            chk("t5_err", 32'(err), 32'd1);
            chk("t5_res0v", 32'(s0_v), 32'd0);
            chk("t5_res1v", 32'(s1_v), 32'd0);
            tick();
        end
        do_reset();
        settle();
        chk("t5_err_cleared", 32'(err), 32'd0);

`ifdef FPU_FMAC_SCHED_STALL_CNT_EN
        // Ten blocked cycles (flush held with a pending request).
        tick();
        for (int t = 0; t < 10; t++) begin
            flush = 1; r0_v = 1;
            tick();
        end
        flush = 0; r0_v = 0;
        settle();
        chk("t6_stall_cnt", 32'(stall_cnt), 32'd10);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
